// File: rtl/score_keeper.sv
// Score/best-score keeper for the flappy-bird game: BCD pass counter, best-score
// latch and a registered display mux that alternates score and best after a game ends.
module score_keeper #(
    parameter int unsigned BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        game_start,
    input  logic        pipe_pass,
    input  logic        game_over,
    output logic [15:0] score,
    output logic [15:0] best,
    output logic [15:0] disp_score,
    output logic        disp_is_best,
    output logic        new_best,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PLAYING = 2'b01,
        OVER    = 2'b10
    } state_t;

    localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
    localparam logic [15:0] SCORE_MAX  = 16'h9999;

    state_t      cur_state;
    state_t      nxt_state;
    logic        start_game;
    logic        end_game;
    logic        pipe_pass_d;
    logic        pass_evt;
    logic [15:0] score_nxt;
    logic [25:0] blink_cnt;
    logic        blink_phase;
    logic [15:0] disp_src;
    logic        disp_src_is_best;

    // Increment packed BCD; the caller guarantees the value is below 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Digit-wise magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided) begin
                if (a[4*i +: 4] > b[4*i +: 4]) begin
                    gt      = 1'b1;
                    decided = 1'b1;
                end else if (a[4*i +: 4] < b[4*i +: 4]) begin
                    decided = 1'b1;
                end
            end
        end
        return gt;
    endfunction

    assign pass_evt = pipe_pass & ~pipe_pass_d;
    assign state    = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Start beats a simultaneous game_over outside PLAYING; 2'b11 falls back to IDLE.
    always_comb begin
        nxt_state  = cur_state;
        start_game = 1'b0;
        end_game   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (game_start) begin
                    nxt_state  = PLAYING;
                    start_game = 1'b1;
                end
            end
            PLAYING: begin
                if (game_over) begin
                    nxt_state = OVER;
                    end_game  = 1'b1;
                end
            end
            OVER: begin
                if (game_start) begin
                    nxt_state  = PLAYING;
                    start_game = 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_pass_d <= 1'b0;
        end else begin
            pipe_pass_d <= pipe_pass;
        end
    end

    // A collision in the same cycle as a pass discards the increment.
    always_comb begin
        score_nxt = score;
        if (start_game) begin
            score_nxt = 16'h0000;
        end else if (cur_state == PLAYING && !game_over && pass_evt &&
                     score != SCORE_MAX) begin
            score_nxt = bcd_inc(score);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= 16'h0000;
        end else begin
            score <= score_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best     <= 16'h0000;
            new_best <= 1'b0;
        end else if (start_game) begin
            new_best <= 1'b0;
        end else if (end_game && bcd_gt(score, best)) begin
            best     <= score;
            new_best <= 1'b1;
        end
    end

    // The counter only runs while staying in OVER, so every entry starts at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (cur_state == OVER && nxt_state == OVER) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end
    end

    always_comb begin
        disp_src         = best;
        disp_src_is_best = 1'b0;
        case (cur_state)
            PLAYING: begin
                disp_src = score;
            end
            OVER: begin
                if (blink_phase) begin
                    disp_src         = best;
                    disp_src_is_best = 1'b1;
                end else begin
                    disp_src = score;
                end
            end
            default: begin
                disp_src = best;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_score   <= 16'h0000;
            disp_is_best <= 1'b0;
        end else begin
            disp_score   <= disp_src;
            disp_is_best <= disp_src_is_best;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: pass counting, saturation, best tracking,
// OVER display alternation and asynchronous reset.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_start = 1'b0;
    logic        pipe_pass = 1'b0;
    logic        game_over = 1'b0;
    logic [15:0] score;
    logic [15:0] best;
    logic [15:0] disp_score;
    logic        disp_is_best;
    logic        new_best;
    logic [1:0]  state;

    int num_checks = 0;
    int num_errors = 0;

    score_keeper #(.BLINK_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .game_start   (game_start),
        .pipe_pass    (pipe_pass),
        .game_over    (game_over),
        .score        (score),
        .best         (best),
        .disp_score   (disp_score),
        .disp_is_best (disp_is_best),
        .new_best     (new_best),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int len);
        pipe_pass = 1'b1;
        tick(len);
        pipe_pass = 1'b0;
        tick(1);
    endtask

    task automatic do_start();
        game_start = 1'b1;
        tick(1);
        game_start = 1'b0;
    endtask

    task automatic do_over();
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
    endtask

    task automatic play_game(input int passes);
        do_start();
        repeat (passes) pulse(1);
        do_over();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick(2);
        check({tag, "_state"}, 32'(state), 32'h0);
        check({tag, "_score"}, 32'(score), 32'h0);
        check({tag, "_best"}, 32'(best), 32'h0);
        check({tag, "_disp"}, 32'(disp_score), 32'h0);
        check({tag, "_disp_is_best"}, 32'(disp_is_best), 32'h0);
        check({tag, "_new_best"}, 32'(new_best), 32'h0);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        do_reset("rst0");

        // Inputs outside PLAYING are ignored.
        pulse(1);
        check("idle_pass", 32'(score), 32'h0);
        do_over();
        check("idle_over", 32'(state), 32'h0);

        // Pulses of 1, 5 and 40 cycles count once each.
        do_start();
        check("start_state", 32'(state), 32'h1);
        check("start_score", 32'(score), 32'h0);
        pulse(1);
        pulse(5);
        check("two_pulses", 32'(score), 32'h0002);
        pipe_pass = 1'b1;
        tick(1);
        check("third_score", 32'(score), 32'h0003);
        check("disp_lag", 32'(disp_score), 32'h0002);
        tick(1);
        check("disp_next", 32'(disp_score), 32'h0003);
        tick(38);
        pipe_pass = 1'b0;
        tick(1);
        check("long_pulse", 32'(score), 32'h0003);
        do_start();
        check("play_start_ign_state", 32'(state), 32'h1);
        check("play_start_ign_score", 32'(score), 32'h0003);
        do_over();
        check("over_state", 32'(state), 32'h2);
        check("over_best", 32'(best), 32'h0003);
        check("over_new_best", 32'(new_best), 32'h1);

        // start and game_over together in OVER: start wins.
        game_start = 1'b1;
        game_over  = 1'b1;
        tick(1);
        game_start = 1'b0;
        game_over  = 1'b0;
        check("both_state", 32'(state), 32'h1);
        check("both_score", 32'(score), 32'h0);
        check("both_new_best", 32'(new_best), 32'h0);
        repeat (20) pulse(1);
        do_over();
        check("best20", 32'(best), 32'h0020);

        // OVER alternation with score 0007, best 0020.
        do_start();
        repeat (7) pulse(1);
        game_over = 1'b1;
        tick(1);
        game_over = 1'b0;
        check("blink_score", 32'(score), 32'h0007);
        check("blink_best", 32'(best), 32'h0020);
        check("blink_new_best", 32'(new_best), 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (((i / 4) % 2) == 1) begin
                check($sformatf("blink_disp_%0d", i), 32'(disp_score), 32'h0020);
                check($sformatf("blink_isbest_%0d", i), 32'(disp_is_best), 32'h1);
            end else begin
                check($sformatf("blink_disp_%0d", i), 32'(disp_score), 32'h0007);
                check($sformatf("blink_isbest_%0d", i), 32'(disp_is_best), 32'h0);
            end
        end
        do_start();
        check("restart_score", 32'(score), 32'h0);
        tick(1);
        check("restart_disp", 32'(disp_score), 32'h0);
        check("restart_isbest", 32'(disp_is_best), 32'h0);

        // Best across games 12, 12, 9.
        do_reset("rst1");
        play_game(12);
        check("g1_best", 32'(best), 32'h0012);
        check("g1_new_best", 32'(new_best), 32'h1);
        play_game(12);
        check("g2_best", 32'(best), 32'h0012);
        check("g2_new_best", 32'(new_best), 32'h0);
        play_game(9);
        check("g3_best", 32'(best), 32'h0012);
        check("g3_new_best", 32'(new_best), 32'h0);
        check("g3_score", 32'(score), 32'h0009);

        // Asynchronous reset mid-game.
        do_start();
        repeat (5) pulse(1);
        check("pre_rst_score", 32'(score), 32'h0005);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'h0);
        check("arst_score", 32'(score), 32'h0);
        check("arst_best", 32'(best), 32'h0);
        check("arst_disp", 32'(disp_score), 32'h0);
        check("arst_isbest", 32'(disp_is_best), 32'h0);
        check("arst_new_best", 32'(new_best), 32'h0);
        pipe_pass = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rel_held_score", 32'(score), 32'h0);
        check("rel_held_state", 32'(state), 32'h0);
        tick(3);
        pipe_pass = 1'b0;
        tick(1);
        pulse(1);
        check("rel_idle_score", 32'(score), 32'h0);

        // Collision and pass edge in the same cycle.
        do_start();
        repeat (4) pulse(1);
        check("coll_pre", 32'(score), 32'h0004);
        pipe_pass = 1'b1;
        game_over = 1'b1;
        tick(1);
        pipe_pass = 1'b0;
        game_over = 1'b0;
        check("coll_state", 32'(state), 32'h2);
        check("coll_score", 32'(score), 32'h0004);
        check("coll_best", 32'(best), 32'h0004);
        check("coll_new_best", 32'(new_best), 32'h1);
        tick(1);
        pulse(1);
        check("over_pass_ign", 32'(score), 32'h0004);

        // BCD carries and saturation.
        do_start();
        repeat (99) pulse(1);
        check("bcd_0099", 32'(score), 32'h0099);
        pulse(1);
        check("bcd_0100", 32'(score), 32'h0100);
        for (int n = 101; n <= 999; n++) pulse(1);
        check("bcd_0999", 32'(score), 32'h0999);
        pulse(1);
        check("bcd_1000", 32'(score), 32'h1000);
        for (int n = 1001; n <= 9999; n++) pulse(1);
        check("bcd_9999", 32'(score), 32'h9999);
        pulse(1);
        check("sat_1", 32'(score), 32'h9999);
        pulse(3);
        check("sat_2", 32'(score), 32'h9999);
        do_over();
        check("sat_best", 32'(best), 32'h9999);
        check("sat_new_best", 32'(new_best), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter BLINK_DIV, default 50000000, clk cycles per half-period of the score/best alternation in OVER; legal range 2..2^26-1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 game_start  input  1  level, synchronous to clk; start/restart request from the game FSM.
REQ-005 pipe_pass  input  1  level, synchronous to clk; high while the bird lies past a pipe's trailing edge; may stay high many cycles.
REQ-006 game_over  input  1  level, synchronous to clk; collision detected.
REQ-007 score  output  16  current score, 4-digit packed BCD, digit 0 in [3:0].
REQ-008 best  output  16  best score since reset, packed BCD.
REQ-009 disp_score  output  16  registered value for the downstream 7-segment display stage, packed BCD.
REQ-010 disp_is_best  output  1  high when disp_score currently carries best.
REQ-011 new_best  output  1  high when the last finished game raised best.
REQ-012 state  output  2  FSM state: 00 IDLE, 01 PLAYING, 10 OVER.

Function
REQ-013 FSM: IDLE -> PLAYING on game_start; PLAYING -> OVER on game_over; OVER -> PLAYING on game_start; encoding 11 unreachable, decoded as IDLE next cycle.
REQ-014 game_start in PLAYING is ignored; game_over in IDLE/OVER is ignored; game_start and game_over both high in IDLE/OVER -> start wins.
REQ-015 Entering PLAYING: score cleared to 0000 and new_best cleared on the same edge.
REQ-016 Pass event = pipe_pass high this cycle and low the previous cycle (registered pipe_pass_d); one event per rising edge of pipe_pass regardless of pulse length.
REQ-017 Pass event in PLAYING increments score by 1 in BCD; new score visible the cycle after the event cycle (1-cycle latency).
REQ-018 BCD increment: a digit at 9 rolls to 0 and carries into the next digit; every digit always within 0..9.
REQ-019 Score saturates: at 9999 a pass event leaves 9999; no wrap to 0000.
REQ-020 Pass events in IDLE or OVER are ignored; pipe_pass_d still tracks pipe_pass in all states.
REQ-021 game_over and pass event in the same PLAYING cycle: game_over wins, increment discarded.
REQ-022 On the PLAYING -> OVER edge: if score > best (BCD compare, most significant digit first) then best <= score and new_best <= 1 on that edge; equal score leaves best and new_best unchanged.
REQ-023 disp_score/disp_is_best registered, 1-cycle latency from source: IDLE -> best,0; PLAYING -> score,0; OVER -> alternating.
REQ-024 OVER alternation: blink counter reset to 0 on entry; first BLINK_DIV cycles show score (disp_is_best=0), next BLINK_DIV show best (1), repeating; counter held at 0 outside OVER.

Reset
REQ-025 rst_n low forces immediately: state IDLE, score 0000, best 0000, disp_score 0000, disp_is_best 0, new_best 0, pipe_pass_d 0, blink counter 0.
REQ-026 Reset mid-game discards score and best; after release block is in IDLE awaiting game_start; a pipe_pass held high across release produces no count (state IDLE).

Verification
REQ-027 Reset, game_start, 3 pipe_pass pulses of lengths 1, 5, 40 cycles -> score 0003, disp_score 0003 one cycle later.
REQ-028 Preload score to 0099 via 99 passes, one more pass -> 0100; continue to 9999, one more pass -> stays 9999.
REQ-029 Game 1 ends at 0012 -> best 0012, new_best 1; game 2 ends at 0012 -> best 0012, new_best 0; game 3 ends at 0009 -> best 0012.
REQ-030 game_over and pass rising edge same cycle at score 0004 -> state OVER, score 0004, best updated to 0004 if larger.
REQ-031 BLINK_DIV=4, OVER with score 0007 best 0020 -> disp_score 0007 x4, 0020 x4, 0007 x4; game_start -> score 0000, disp_score 0000 next cycle.
REQ-032 Assert rst_n low mid-PLAYING at score 0005 -> all outputs 0 asynchronously, state IDLE; pass events ignored until game_start.
